// File: rtl/ccff_ctrl_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ccff_ld_state_t;

  // Number of bitstream words needed to cover the chain (ceiling division).
  function automatic int ccff_num_words(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_word_buffer.sv
// One-entry holding buffer between the bitstream stream and the shift register.
module ccff_word_buffer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              ready,
  output logic              accepted,
  input  logic              pop,
  output logic [WORD_W-1:0] out_data,
  output logic              out_vld
);

  logic              vld;
  logic [WORD_W-1:0] data;

  assign ready    = enable && !vld;
  assign accepted = in_valid && ready;
  assign out_data = data;
  assign out_vld  = vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
    end else if (clear) begin
      vld <= 1'b0;
    end else if (accepted) begin
      vld <= 1'b1;
    end else if (pop) begin
      vld <= 1'b0;
    end
  end

  // NOTE: the payload register needs no reset; it is only read while vld is set.
  always_ff @(posedge clk) begin
    if (accepted) begin
      data <= in_data;
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words MSB-first onto a tile configuration chain.
module ccff_bitstream_loader
  import ccff_ctrl_pkg::*;
#(
  parameter  int WORD_W    = 8,
  parameter  int CHAIN_LEN = 20,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_left
);

  localparam int NUM_WORDS = ccff_num_words(CHAIN_LEN, WORD_W);
  localparam int WC_W      = $clog2(NUM_WORDS + 1);
  localparam int SC_W      = $clog2(WORD_W + 1);

  ccff_ld_state_t    state;
  logic [WORD_W-1:0] sreg;
  logic [SC_W-1:0]   sreg_cnt;
  logic [WC_W-1:0]   words_taken;
  logic [CNT_W-1:0]  bits_left_q;
  logic              busy_q;
  logic              done_q;

  logic              hold_vld;
  logic [WORD_W-1:0] hold_data;
  logic              accepted;
  logic              buf_enable;
  logic              buf_clear;
  logic              shifting;
  logic              refill;

  // Word counter closes the stream once the chain's worth of words is taken.
  assign buf_enable = busy_q && (words_taken != WC_W'(NUM_WORDS));
  assign buf_clear  = ((state == IDLE) && start) || (state == DONE);
  assign shifting   = (state == SHIFT) && (sreg_cnt != '0);
  assign refill     = (state == SHIFT) && hold_vld &&
                      ((sreg_cnt == '0) || ((sreg_cnt == SC_W'(1)) && shifting));

  ccff_word_buffer #(
    .WORD_W(WORD_W)
  ) u_hold (
    .clk      (prog_clk),
    .rst_n    (prog_reset_n),
    .clear    (buf_clear),
    .enable   (buf_enable),
    .in_data  (bs_data),
    .in_valid (bs_valid),
    .ready    (bs_ready),
    .accepted (accepted),
    .pop      (refill),
    .out_data (hold_data),
    .out_vld  (hold_vld)
  );

  assign ccff_head     = sreg[WORD_W-1];
  assign ccff_shift_en = shifting;
  assign busy          = busy_q;
  assign done          = done_q;
  assign bits_left     = bits_left_q;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state       <= IDLE;
      sreg        <= '0;
      sreg_cnt    <= '0;
      words_taken <= '0;
      bits_left_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state       <= SHIFT;
            busy_q      <= 1'b1;
            bits_left_q <= CNT_W'(CHAIN_LEN);
            sreg        <= '0;
            sreg_cnt    <= '0;
            words_taken <= '0;
          end
        end

        SHIFT: begin
          if (accepted) begin
            words_taken <= words_taken + WC_W'(1);
          end
          // A refill on the last valid bit replaces the shift, keeping the stream gap-free.
          if (refill) begin
            sreg     <= hold_data;
            sreg_cnt <= SC_W'(WORD_W);
          end else if (shifting) begin
            sreg     <= {sreg[WORD_W-2:0], 1'b0};
            sreg_cnt <= sreg_cnt - SC_W'(1);
          end
          if (shifting) begin
            bits_left_q <= bits_left_q - CNT_W'(1);
            if (bits_left_q == CNT_W'(1)) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end

        DONE: begin
          // Residual bits of a partial final word are dropped here.
          state    <= IDLE;
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
          sreg     <= '0;
          sreg_cnt <= '0;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Randomised self-checking bench for ccff_bitstream_loader at chain lengths 20, 16 and 1.
module tb_ccff_bitstream_loader;

  logic       clk;
  logic       rst_n;
  logic [2:0] start_v;
  logic [2:0] valid_v;
  logic [7:0] data_v [3];
  logic [2:0] ready_v;
  logic [2:0] head_v;
  logic [2:0] se_v;
  logic [2:0] busy_v;
  logic [2:0] done_v;
  logic [4:0] bl20;
  logic [4:0] bl16;
  logic [0:0] bl1;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(20)) dut20 (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start_v[0]), .bs_data(data_v[0]),
    .bs_valid(valid_v[0]), .bs_ready(ready_v[0]), .ccff_head(head_v[0]),
    .ccff_shift_en(se_v[0]), .busy(busy_v[0]), .done(done_v[0]), .bits_left(bl20));

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(16)) dut16 (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start_v[1]), .bs_data(data_v[1]),
    .bs_valid(valid_v[1]), .bs_ready(ready_v[1]), .ccff_head(head_v[1]),
    .ccff_shift_en(se_v[1]), .busy(busy_v[1]), .done(done_v[1]), .bits_left(bl16));

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(1)) dut1 (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start_v[2]), .bs_data(data_v[2]),
    .bs_valid(valid_v[2]), .bs_ready(ready_v[2]), .ccff_head(head_v[2]),
    .ccff_shift_en(se_v[2]), .busy(busy_v[2]), .done(done_v[2]), .bits_left(bl1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int get_bl(input int sel);
    case (sel)
      0:       return int'(bl20);
      1:       return int'(bl16);
      default: return int'(bl1);
    endcase
  endfunction

  // One load on instance sel. The model is the concatenation of the accepted
  // words, MSB first, truncated to chain_len bits.
  task automatic run_load(input int sel, input int chain_len, input bit fixed,
                          input int gap_after, input int gap_len, input int drop_pct,
                          input int restart_cyc, input int reset_shift);
    logic [7:0]  words[$];
    logic [7:0]  w;
    logic [31:0] exp_val = '0;
    logic [31:0] got_val = '0;
    int nwords = (chain_len + 7) / 8;
    int widx = 0, nshift = 0, ndone = 0, done_cyc = -1;
    int first_se = -1, last_se = -1, run_gap = 0, max_gap = 0, gap_left = 0;
    bit aborted = 1'b0;

    for (int i = 0; i < nwords + 4; i++) words.push_back(8'($urandom_range(0, 255)));
    if (fixed) begin
      words[0] = 8'hA5;
      words[1] = 8'h3C;
      words[2] = 8'hF0;
    end
    for (int i = 0; i < chain_len; i++) begin
      w = words[i / 8];
      exp_val = {exp_val[30:0], w[7 - (i % 8)]};
    end

    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("busy_after_start", 32'(busy_v[sel]), 32'd1);
        check("ready_after_start", 32'(ready_v[sel]), 32'd1);
        check("bits_left_loaded", 32'(get_bl(sel)), 32'(chain_len));
      end
      if (se_v[sel]) begin
        check("bits_left_track", 32'(get_bl(sel)), 32'(chain_len - nshift));
        got_val = {got_val[30:0], head_v[sel]};
        nshift++;
        if (first_se < 0) first_se = c;
        else if (run_gap > max_gap) max_gap = run_gap;
        run_gap = 0;
        last_se = c;
      end else if (first_se >= 0) begin
        run_gap++;
      end
      if (done_v[sel]) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (reset_shift >= 0 && nshift == reset_shift) begin
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs",
              {27'd0, ready_v[sel], head_v[sel], se_v[sel], busy_v[sel], done_v[sel]}, 32'd0);
        check("rst_async_bits_left", 32'(get_bl(sel)), 32'd0);
        start_v[sel] = 1'b0;
        valid_v[sel] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        check("idle_busy", 32'(busy_v[sel]), 32'd0);
        check("idle_ready", 32'(ready_v[sel]), 32'd0);
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;

      start_v[sel] = (c == 0) || (c == restart_cyc);
      if (gap_left > 0) begin
        valid_v[sel] = 1'b0;
        gap_left--;
      end else if (drop_pct > 0 && int'($urandom_range(0, 99)) < drop_pct) begin
        valid_v[sel] = 1'b0;
      end else begin
        valid_v[sel] = 1'b1;
      end
      data_v[sel] = words[(widx < words.size()) ? widx : words.size() - 1];
      if (valid_v[sel] && ready_v[sel]) begin
        widx++;
        if (widx == gap_after) gap_left = gap_len;
      end
    end
    start_v[sel] = 1'b0;
    valid_v[sel] = 1'b0;

    if (!aborted) begin
      check("done_seen", 32'(done_cyc >= 0), 32'd1);
      check("done_pulses", 32'(ndone), 32'd1);
      check("shift_count", 32'(nshift), 32'(chain_len));
      check("bit_sequence", got_val, exp_val);
      check("handshakes", 32'(widx), 32'(nwords));
      check("done_after_last_shift", 32'(done_cyc), 32'(last_se + 1));
      if (fixed) check("fixed_pattern", got_val, 32'hA53CF);
      if (drop_pct == 0) begin
        check("first_shift_cycle", 32'(first_se), 32'd3);
        check("max_gap", 32'(max_gap <= gap_len), 32'd1);
      end
      if (drop_pct == 0 && gap_len == 0) begin
        check("contiguous", 32'(last_se - first_se + 1), 32'(chain_len));
        check("done_cycle", 32'(done_cyc), 32'(3 + chain_len));
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start_v = '0;
    valid_v = '0;
    for (int i = 0; i < 3; i++) data_v[i] = '0;
    #3;
    check("reset_outputs",
          {27'd0, ready_v[0], head_v[0], se_v[0], busy_v[0], done_v[0]}, 32'd0);
    check("reset_bits_left", 32'(bl20), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_load(0, 20, 1'b1, 0, 0, 0, -1, -1);   // fixed words, continuous
    run_load(0, 20, 1'b1, 2, 5, 0, -1, -1);   // 5-cycle valid gap after word 2
    run_load(0, 20, 1'b0, 1, 12, 0, -1, -1);  // long gap forces a visible stall
    run_load(1, 16, 1'b0, 0, 0, 0, -1, -1);   // exact multiple of word width
    run_load(0, 20, 1'b0, 0, 0, 0, 8, -1);    // start pulsed mid-load
    run_load(0, 20, 1'b0, 0, 0, 0, -1, 7);    // reset at shift 7
    run_load(0, 20, 1'b0, 0, 0, 0, -1, -1);   // full reload after reset
    run_load(2, 1, 1'b0, 0, 0, 0, -1, -1);    // single-bit chain
    for (int k = 0; k < 6; k++) begin
      case (k % 3)
        0:       run_load(0, 20, 1'b0, 0, 0, int'($urandom_range(20, 60)), -1, -1);
        1:       run_load(1, 16, 1'b0, 0, 0, int'($urandom_range(20, 60)), -1, -1);
        default: run_load(2, 1, 1'b0, 0, 0, int'($urandom_range(20, 60)), -1, -1);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
